// File: rtl/rpn_pop_exec_pkg.sv
// Shared definitions for the RPN calculator: operation codes, pop-path FSM states
// and seven-segment glyphs (active-low, segment order gfedcba).
package rpn_pop_exec_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_DROP = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_A,
      S_LATCH_A,
      S_LATCH_B,
      S_WRITE,
      S_FIN_DROP,
      S_ERR,
      S_DONE
   } state_t;

   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [6:0] SEG_ONE   = 7'h79;
   localparam logic [6:0] SEG_TWO   = 7'h24;
   localparam logic [6:0] SEG_THREE = 7'h30;
   localparam logic [6:0] SEG_FOUR  = 7'h19;
   localparam logic [6:0] SEG_FIVE  = 7'h12;
   localparam logic [6:0] SEG_SIX   = 7'h02;
   localparam logic [6:0] SEG_SEVEN = 7'h78;
   localparam logic [6:0] SEG_EIGHT = 7'h00;
   localparam logic [6:0] SEG_NINE  = 7'h10;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_O     = 7'h23;
   localparam logic [6:0] SEG_OFF   = 7'h7F;

   // Glyph for digit position pos (2 = leftmost) when the top level shows "Err".
   function automatic logic [6:0] err_glyph(input logic [1:0] pos);
      logic [6:0] g;
      case (pos)
         2'd2:    g = SEG_E;
         2'd1:    g = SEG_R;
         2'd0:    g = SEG_R;
         default: g = SEG_OFF;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/rpn_pop_exec_alu.sv
// Combinational RPN ALU: R = B op A with a per-operation status flag
// (carry, borrow, or nonzero high half of the product); DROP passes A through.
module rpn_alu
   import rpn_pop_exec_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r,
   output logic             flag
);

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;

   assign sum  = {1'b0, b} + {1'b0, a};
   assign diff = {1'b0, b} - {1'b0, a};
   assign prod = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, a};

   always_comb begin
      r    = a;
      flag = 1'b0;
      case (op)
         OP_ADD: begin
            r    = sum[WIDTH-1:0];
            flag = sum[WIDTH];
         end
         OP_SUB: begin
            r    = diff[WIDTH-1:0];
            flag = diff[WIDTH];
         end
         OP_MUL: begin
            r    = prod[WIDTH-1:0];
            flag = |prod[2*WIDTH-1:WIDTH];
         end
         default: begin
            r    = a;
            flag = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rpn_pop_exec.sv
// Pop/execute side of the RPN stack: reads one or two operands from the stack RAM,
// writes a binary result back in place and requests the new stack pointer.
module rpn_pop_exec
   import rpn_pop_exec_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 8,
   parameter int BASE   = 1
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] sp,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              sp_load,
   output logic [ADDR_W-1:0] sp_next,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic              flag,
   output logic              err
);

   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] TWO_A    = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] MIN_BIN  = ADDR_W'(BASE + 2);
   localparam logic [ADDR_W-1:0] MIN_DROP = ADDR_W'(BASE + 1);

   state_t            state_reg, state_next;
   logic [1:0]        op_reg;
   logic [ADDR_W-1:0] sp_reg;
   logic [WIDTH-1:0]  a_reg, b_reg;
   logic [WIDTH-1:0]  result_reg;
   logic              flag_reg, err_reg;

   logic              accept, underflow;
   logic [WIDTH-1:0]  alu_r;
   logic              alu_flag;

   rpn_alu #(.WIDTH(WIDTH)) u_alu (
      .op   (op_reg),
      .a    (a_reg),
      .b    (b_reg),
      .r    (alu_r),
      .flag (alu_flag)
   );

   // The done cycle already reports busy=0, so a start there is honoured too.
   assign accept    = start && (state_reg == S_IDLE || state_reg == S_DONE);
   assign underflow = (op == OP_DROP) ? (sp < MIN_DROP) : (sp < MIN_BIN);

   assign busy   = !(state_reg == S_IDLE || state_reg == S_DONE);
   assign done   = (state_reg == S_DONE);
   assign result = result_reg;
   assign flag   = flag_reg;
   assign err    = err_reg;

   always_comb begin
      state_next = state_reg;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      sp_load    = 1'b0;
      sp_next    = '0;
      case (state_reg)
         S_IDLE, S_DONE: begin
            state_next = S_IDLE;
            if (accept)
               state_next = underflow ? S_ERR : S_RD_A;
         end
         S_RD_A: begin
            mem_addr   = sp_reg - ONE_A;
            state_next = S_LATCH_A;
         end
         S_LATCH_A: begin
            if (op_reg == OP_DROP) begin
               state_next = S_FIN_DROP;
            end else begin
               mem_addr   = sp_reg - TWO_A;
               state_next = S_LATCH_B;
            end
         end
         S_LATCH_B: state_next = S_WRITE;
         S_WRITE: begin
            mem_addr   = sp_reg - TWO_A;
            mem_we     = 1'b1;
            mem_wdata  = alu_r;
            sp_load    = 1'b1;
            sp_next    = sp_reg - ONE_A;
            state_next = S_DONE;
         end
         S_FIN_DROP: begin
            sp_load    = 1'b1;
            sp_next    = sp_reg - ONE_A;
            state_next = S_DONE;
         end
         S_ERR:   state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         op_reg     <= '0;
         sp_reg     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         flag_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg  <= op;
            sp_reg  <= sp;
            err_reg <= underflow;
         end
         if (state_reg == S_LATCH_A)
            a_reg <= mem_rdata;
         if (state_reg == S_LATCH_B)
            b_reg <= mem_rdata;
         // With op_reg = DROP the ALU passes A through and clears the flag.
         if (state_reg == S_WRITE || state_reg == S_FIN_DROP) begin
            result_reg <= alu_r;
            flag_reg   <= alu_flag;
         end
      end
   end

endmodule

// File: tb/tb_rpn_pop_exec.sv
// Self-checking bench for rpn_pop_exec: behavioural stack RAM, output monitor,
// and a scoreboard of expected per-operation outcomes.
module tb_rpn_pop_exec;

   localparam int WIDTH  = 8;
   localparam int ADDR_W = 8;
   localparam int BASE   = 1;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [1:0] op;
   logic [7:0] sp, mem_rdata, mem_addr, mem_wdata, sp_next, result;
   logic       mem_we, sp_load, busy, done, flag, err;

   always #10 clk = ~clk;

   rpn_pop_exec #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BASE(BASE)) dut (
      .CLOCK_50  (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .sp        (sp),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .sp_load   (sp_load),
      .sp_next   (sp_next),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .flag      (flag),
      .err       (err)
   );

   // Stack RAM with registered read; the bench preloads it through the pre_* port.
   logic [7:0] ram [0:255];
   logic       pre_we = 1'b0;
   logic [7:0] pre_addr = '0, pre_data = '0;

   always @(posedge clk) begin
      if (pre_we)
         ram[pre_addr] <= pre_data;
      else if (mem_we)
         ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         wr_cnt = 0, sl_cnt = 0, done_cnt = 0, done_cyc = 0, ovl_cnt = 0;
   logic [7:0] wr_addr = '0, wr_data = '0, sl_val = '0;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_cnt++;
         wr_addr = mem_addr;
         wr_data = mem_wdata;
      end
      if (sp_load) begin
         sl_cnt++;
         sl_val = sp_next;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (done && (mem_we || sp_load))
         ovl_cnt++;
   end

   typedef struct {
      logic [7:0] res;
      logic       flg;
      logic       er;
      int         lat;
      int         nwr;
      logic [7:0] waddr;
      logic [7:0] wdata;
      int         nsl;
      logic [7:0] spn;
   } exp_t;

   exp_t       sb_q[$];
   int         n_cmp = 0, n_bad = 0;
   logic [7:0] last_res = '0;
   logic       last_flg = 1'b0;

   // Reference arithmetic in plain integers: returns {flag, R} for B op A.
   function automatic logic [8:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
      int s;
      int r;
      logic f;
      case (o)
         2'd0: begin s = int'(b) + int'(a); r = s % 256; f = (s > 255); end
         2'd1: begin s = int'(b) - int'(a); r = (s + 256) % 256; f = (s < 0); end
         2'd2: begin s = int'(b) * int'(a); r = s % 256; f = (s > 255); end
         default: begin r = int'(a); f = 1'b0; end
      endcase
      return {f, 8'(r)};
   endfunction

   task automatic poke(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = addr; pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Issues one operation, pushes its expected outcome and checks it at done.
   task automatic test_single_op(input string name, input logic [1:0] o, input logic [7:0] s);
      exp_t       e, x;
      int         c0, d0, w0, s0, v0, need;
      bit         ok;
      logic [8:0] m;
      logic [7:0] ia, ib;
      need = (o == 2'd3) ? 1 : 2;
      ia = s - 8'd1;
      ib = s - 8'd2;
      if (int'(s) < BASE + need) begin
         e = '{res: last_res, flg: last_flg, er: 1'b1, lat: 2, nwr: 0,
               waddr: 8'h00, wdata: 8'h00, nsl: 0, spn: 8'h00};
      end else begin
         m = model(o, ram[ia], ram[ib]);
         e = '{res: m[7:0], flg: m[8], er: 1'b0, lat: (o == 2'd3) ? 4 : 5,
               nwr: (o == 2'd3) ? 0 : 1, waddr: ib, wdata: m[7:0], nsl: 1, spn: ia};
      end
      sb_q.push_back(e);
      @(negedge clk);
      c0 = cyc; d0 = done_cnt; w0 = wr_cnt; s0 = sl_cnt; v0 = ovl_cnt;
      sp = s; op = o; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); #1;
         if (done_cnt != d0) ok = 1'b1;
      end
      x = sb_q.pop_front();
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s timeout: no done seen, required done within 20 cycles", name);
         return;
      end
      n_cmp++; if (done_cyc - c0 != x.lat) begin n_bad++; $display("FAIL %s latency: got %0d required %0d", name, done_cyc - c0, x.lat); end
      n_cmp++; if (result !== x.res) begin n_bad++; $display("FAIL %s result: got %h required %h", name, result, x.res); end
      n_cmp++; if (flag !== x.flg) begin n_bad++; $display("FAIL %s flag: got %b required %b", name, flag, x.flg); end
      n_cmp++; if (err !== x.er) begin n_bad++; $display("FAIL %s err: got %b required %b", name, err, x.er); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_done: got %b required 0", name, busy); end
      n_cmp++; if (wr_cnt - w0 != x.nwr) begin n_bad++; $display("FAIL %s write_count: got %0d required %0d", name, wr_cnt - w0, x.nwr); end
      if (x.nwr == 1) begin
         n_cmp++; if (wr_addr !== x.waddr) begin n_bad++; $display("FAIL %s write_addr: got %h required %h", name, wr_addr, x.waddr); end
         n_cmp++; if (wr_data !== x.wdata) begin n_bad++; $display("FAIL %s write_data: got %h required %h", name, wr_data, x.wdata); end
      end
      n_cmp++; if (sl_cnt - s0 != x.nsl) begin n_bad++; $display("FAIL %s sp_load_count: got %0d required %0d", name, sl_cnt - s0, x.nsl); end
      if (x.nsl == 1) begin
         n_cmp++; if (sl_val !== x.spn) begin n_bad++; $display("FAIL %s sp_next: got %h required %h", name, sl_val, x.spn); end
      end
      n_cmp++; if (ovl_cnt != v0) begin n_bad++; $display("FAIL %s done_overlap: got %0d required 0", name, ovl_cnt - v0); end
      if (!x.er) begin
         last_res = x.res;
         last_flg = x.flg;
      end
      $display("op %-8s code=%0d sp=%0d -> result=%h flag=%b err=%b latency=%0d", name, o, s, result, flag, err, done_cyc - c0);
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 2'd0; sp = 8'(BASE);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #1;
      n_cmp++; if ({busy, done, mem_we, sp_load, flag, err} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl: got busy,done,we,spl,flag,err=%b required 000000", {busy, done, mem_we, sp_load, flag, err}); end
      n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL reset_result: got %h required 00", result); end
      n_cmp++; if ({mem_addr, mem_wdata, sp_next} !== 24'h0) begin n_bad++; $display("FAIL reset_bus: got addr=%h wdata=%h sp_next=%h required 0", mem_addr, mem_wdata, sp_next); end
      last_res = '0; last_flg = 1'b0;
      $display("reset released: result=%h err=%b busy=%b", result, err, busy);
   endtask

   task automatic test_add;
      poke(8'd1, 8'd5); poke(8'd2, 8'd3);
      test_single_op("add", 2'd0, 8'd3);
      n_cmp++; if (ram[1] !== 8'd8 || result !== 8'd8) begin n_bad++; $display("FAIL add_plan: got ram1=%h result=%h required 08", ram[1], result); end
   endtask

   task automatic test_sub;
      poke(8'd1, 8'd3); poke(8'd2, 8'd5);
      test_single_op("sub", 2'd1, 8'd3);
      n_cmp++; if (ram[1] !== 8'hFE || flag !== 1'b1) begin n_bad++; $display("FAIL sub_plan: got ram1=%h flag=%b required FE 1", ram[1], flag); end
   endtask

   task automatic test_mul;
      poke(8'd1, 8'h20); poke(8'd2, 8'h10);
      test_single_op("mul_hi", 2'd2, 8'd3);
      n_cmp++; if (result !== 8'h00 || flag !== 1'b1) begin n_bad++; $display("FAIL mul_hi_plan: got result=%h flag=%b required 00 1", result, flag); end
      poke(8'd1, 8'h0F); poke(8'd2, 8'h11);
      test_single_op("mul_lo", 2'd2, 8'd3);
      n_cmp++; if (result !== 8'hFF || flag !== 1'b0) begin n_bad++; $display("FAIL mul_lo_plan: got result=%h flag=%b required FF 0", result, flag); end
   endtask

   task automatic test_underflow_drop;
      poke(8'd1, 8'h42);
      test_single_op("add_uf", 2'd0, 8'd2);
      test_single_op("drop", 2'd3, 8'd2);
      n_cmp++; if (result !== 8'h42 || err !== 1'b0) begin n_bad++; $display("FAIL drop_plan: got result=%h err=%b required 42 0", result, err); end
   endtask

   // DROP on an empty stack with an extra start pulse while busy: one done only.
   task automatic test_back_to_back;
      int c0, d0, w0, s0;
      exp_t x;
      sb_q.push_back('{res: last_res, flg: last_flg, er: 1'b1, lat: 2, nwr: 0,
                       waddr: 8'h00, wdata: 8'h00, nsl: 0, spn: 8'h00});
      @(negedge clk);
      c0 = cyc; d0 = done_cnt; w0 = wr_cnt; s0 = sl_cnt;
      sp = 8'(BASE); op = 2'd3; start = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b required 1", busy); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      x = sb_q.pop_front();
      n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d required 1", done_cnt - d0); end
      n_cmp++; if (done_cyc - c0 != x.lat) begin n_bad++; $display("FAIL b2b_latency: got %0d required %0d", done_cyc - c0, x.lat); end
      n_cmp++; if (err !== x.er || result !== x.res) begin n_bad++; $display("FAIL b2b_status: got err=%b result=%h required %b %h", err, result, x.er, x.res); end
      n_cmp++; if (wr_cnt != w0 || sl_cnt != s0) begin n_bad++; $display("FAIL b2b_side_effects: got writes=%0d sp_loads=%0d required 0 0", wr_cnt - w0, sl_cnt - s0); end
      $display("op %-8s code=3 sp=%0d -> err=%b dones=%0d latency=%0d", "drop_uf", BASE, err, done_cnt - d0, done_cyc - c0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++) begin
         poke(8'd1, 8'($urandom_range(0, 255)));
         poke(8'd2, 8'($urandom_range(0, 255)));
         test_single_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), 8'd3);
      end
   endtask

   task automatic test_reset_abort;
      int w0, s0, d0;
      logic [7:0] keep;
      poke(8'd1, 8'h11); poke(8'd2, 8'h22);
      keep = ram[1];
      @(negedge clk);
      w0 = wr_cnt; s0 = sl_cnt; d0 = done_cnt;
      sp = 8'd3; op = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if ({busy, done, mem_we, sp_load, flag, err} !== 6'b0) begin n_bad++; $display("FAIL abort_ctrl: got busy,done,we,spl,flag,err=%b required 000000", {busy, done, mem_we, sp_load, flag, err}); end
      n_cmp++; if (result !== 8'h00 || mem_addr !== 8'h00 || sp_next !== 8'h00) begin n_bad++; $display("FAIL abort_values: got result=%h addr=%h sp_next=%h required 00", result, mem_addr, sp_next); end
      reset = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      n_cmp++; if (wr_cnt != w0 || sl_cnt != s0 || done_cnt != d0) begin n_bad++; $display("FAIL abort_side_effects: got writes=%0d sp_loads=%0d dones=%0d required 0 0 0", wr_cnt - w0, sl_cnt - s0, done_cnt - d0); end
      n_cmp++; if (ram[1] !== keep) begin n_bad++; $display("FAIL abort_ram: got %h required %h", ram[1], keep); end
      last_res = '0; last_flg = 1'b0;
      $display("reset during LATCH_B of add: result=%h busy=%b writes=%0d", result, busy, wr_cnt - w0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'd0; sp = 8'(BASE);
      test_reset;
      test_add;
      test_sub;
      test_mul;
      test_underflow_drop;
      test_back_to_back;
      test_random;
      test_reset_abort;
      test_add;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rpn_pop_exec.md
Name: rpn_pop_exec

Overview:
Read side of the RPN calculator stack. On an operation request it pops the top one or two entries from the stack RAM and computes the result. Binary operations push the result back in place of the popped entries, and the block updates the stack pointer through a load request to the stack-pointer register. It complements the push path, which writes switch data at SP and increments SP.

Parameters:
WIDTH, 8, data word width
ADDR_W, 8, stack RAM address and stack-pointer width
BASE, 1, address of bottom stack slot; stack is empty when sp == BASE

Ports:
CLOCK_50  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle operation request, ignored unless busy == 0
op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DROP; sampled when start is accepted
sp  in  ADDR_W  current stack pointer (next free slot); entries occupy BASE..sp-1
mem_rdata  in  WIDTH  stack RAM read data, valid one cycle after mem_addr is presented
mem_addr  out  ADDR_W  stack RAM address
mem_we  out  1  stack RAM write enable
mem_wdata  out  WIDTH  stack RAM write data
sp_load  out  1  one-cycle request to load sp_next into the stack-pointer register
sp_next  out  ADDR_W  new stack-pointer value
busy  out  1  high from the accepted start until done
done  out  1  one-cycle completion pulse, on success or error
result  out  WIDTH  last computed value (DROP: the popped value); held until the next success
flag  out  1  ADD carry-out, SUB borrow, MUL high byte nonzero; 0 for DROP
err  out  1  stack underflow; sticky until reset or next accepted start

Behaviour:
- Reset (sync, highest priority, aborts any operation): state IDLE; mem_we=0, sp_load=0, busy=0, done=0, result=0, flag=0, err=0, mem_addr=0, mem_wdata=0, sp_next=0.
- Operand naming: A = top entry at sp-1; B = entry below it at sp-2.
- All address arithmetic is ADDR_W-bit unsigned. Operand and result arithmetic is WIDTH-bit, wrapping.
- IDLE:
  - start=1: latch op, clear err, busy=1.
  - Underflow check uses the sp value at the start cycle. Underflow is sp < BASE+2 for ADD/SUB/MUL, sp < BASE+1 for DROP; on underflow go to ERR.
  - Otherwise go to RD_A.
- RD_A: mem_addr=sp-1.
- LATCH_A: capture A from mem_rdata.
  - DROP: go to FIN_DROP.
  - Otherwise set mem_addr=sp-2 and go to LATCH_B.
- LATCH_B: capture B and go to WRITE.
- WRITE:
  - mem_addr=sp-2, mem_we=1, mem_wdata=R.
  - R is B+A, B-A, or low WIDTH bits of B*A.
  - sp_load=1, sp_next=sp-1; result=R; flag updated.
  - Go to DONE.
- FIN_DROP: sp_load=1, sp_next=sp-1; result=A; flag=0; go to DONE.
- ERR: err=1, no RAM write, no sp_load; go to DONE.
- DONE: done=1, busy=0; go to IDLE.
- Latency from the start cycle to the done cycle:
  - binary op: 5 cycles;
  - DROP: 4 cycles;
  - underflow: 2 cycles.
- sp is assumed stable while busy. The push path must be gated with busy at top level; simultaneous push and pop is not permitted.
- start while busy is ignored, with no queueing.
- mem_we and sp_load are never asserted in the same cycle as done.
- sp_load fires exactly once per successful operation.

Decomposition:
- Shared include rpn_defs.vh holds:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_DROP;
  - state encodings for S_IDLE..S_DONE;
  - the seven-segment glyph constants (ZERO..NINE, E, r, o, OFF), so top level can show "Err" when err=1.
- One natural sub-module: rpn_alu. It is combinational, takes (op, A, B) and returns (R, flag), and is instantiated once. The FSM and the operand/result registers stay in rpn_pop_exec.

Test Plan:
- Stack [BASE]=5, [BASE+1]=3, sp=3; start op=ADD -> read 2 then 1, write addr 1 data 8, sp_next=2 with sp_load, done at start+5, result=8, flag=0, err=0.
- Stack 3 then 5 (B=3, A=5), sp=3, op=SUB -> write 0xFE at addr 1, flag=1 (borrow), sp_next=2.
- B=0x20, A=0x10, op=MUL -> mem_wdata=0x00, flag=1. Then with B=0x0F, A=0x11: mem_wdata=0xFF, flag=0.
- sp=2 (one entry), op=ADD -> err=1, no mem_we, no sp_load, done at start+2. Next op=DROP with the same sp -> err clears, result=the entry, sp_next=1, done at start+4.
- sp=BASE, op=DROP -> err=1. A second start pulse asserted while busy is ignored, with exactly one done.
- Assert reset during LATCH_B of an ADD -> next cycle state IDLE, all outputs at reset values, no RAM write and no sp_load issued.
